// File: rtl/ldpc_pkg.sv
// Shared sizes, state encoding and PE/column decode helpers for the LDPC frame I/O sequencer.
package ldpc_pkg;
  localparam int K              = 6;
  localparam int L              = 32;
  localparam int ADDR_WIDTH     = 5;
  localparam int MESSAGE_WIDTH  = 5;
  localparam int KK             = K * K;
  localparam int N_FRAME        = K * K * L;
  localparam int N_WIDTH        = 11;
  localparam int PE_IDX_WIDTH   = N_WIDTH - ADDR_WIDTH;
  localparam int DECODE_CYCLES  = 640;
  localparam int DEC_CNT_WIDTH  = $clog2(DECODE_CYCLES + 1);
  localparam int READ_LATENCY   = 6;
  localparam int FIFO_DEPTH     = 8;
  localparam int FIFO_CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, LOAD, DECODE, READ, DRAIN} io_state_t;

  // PE index p = i + K*j is column-major, so the PE select bit is p itself.
  function automatic logic [KK-1:0] pe_onehot(input logic [PE_IDX_WIDTH-1:0] p);
    return KK'(1) << p;
  endfunction

  function automatic logic [K-1:0] col_onehot(input logic [PE_IDX_WIDTH-1:0] p);
    logic [K-1:0] c;
    c = '0;
    for (int j = 0; j < K; j++) begin
      if (int'(p) >= j * K && int'(p) < (j + 1) * K) c[j] = 1'b1;
    end
    return c;
  endfunction
endpackage

// File: rtl/ldpc_rd_fifo.sv
// Synchronous skid FIFO for decoded words; head word is presented combinationally.
module ldpc_rd_fifo
  import ldpc_pkg::*;
#(
  parameter int WIDTH = KK,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (count != CW'(DEPTH));
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ldpc_frame_io_ctrl.sv
// Frame sequencer for the LDPC decoder: loads LLRs into the PE array, runs en for a fixed
// window, then sweeps read addresses and streams decoded words out through a credit-guarded FIFO.
module ldpc_frame_io_ctrl
  import ldpc_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     llr_valid,
  output logic                     llr_ready,
  input  logic [MESSAGE_WIDTH-1:0] llr_data,
  input  logic                     llr_last,
  output logic [MESSAGE_WIDTH-1:0] int_in,
  output logic [ADDR_WIDTH-1:0]    load_add_in,
  output logic [KK-1:0]            pe_select,
  output logic [K-1:0]             column_select,
  output logic                     en,
  output logic [ADDR_WIDTH-1:0]    read_add_in,
  input  logic [KK-1:0]            dec_out_fin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [KK-1:0]            out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     frame_err,
  output io_state_t                state
);
  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid never waits on ready, and out_data/out_last hold while out_valid & !out_ready.
  localparam int SUM_W = FIFO_CNT_WIDTH + 1;

  io_state_t                 state_q, state_d;
  logic [N_WIDTH-1:0]        n_q;
  logic [DEC_CNT_WIDTH-1:0]  dec_cnt_q;
  logic [ADDR_WIDTH-1:0]     raddr_q, ocnt_q;
  logic [READ_LATENCY-1:0]   vld_sr;
  logic [FIFO_CNT_WIDTH-1:0] inflight_q, fifo_count;
  logic [PE_IDX_WIDTH-1:0]   pe_idx;
  logic fifo_empty, llr_hs, rd_issue, push, pop, last_sample, credit_ok, dec_done;

  assign llr_hs      = llr_valid & llr_ready;
  assign last_sample = (n_q == N_WIDTH'(N_FRAME - 1));
  assign pe_idx      = n_q[N_WIDTH-1:ADDR_WIDTH];
  assign dec_done    = (dec_cnt_q == DEC_CNT_WIDTH'(DECODE_CYCLES));
  assign credit_ok   = ({1'b0, fifo_count} + {1'b0, inflight_q}) < SUM_W'(FIFO_DEPTH);
  assign push        = vld_sr[READ_LATENCY-1];
  assign out_valid   = ~fifo_empty;
  assign pop         = out_valid & out_ready;
  assign out_last    = out_valid & (ocnt_q == ADDR_WIDTH'(L - 1));
  assign read_add_in = raddr_q;
  assign busy        = (state_q != IDLE);
  assign state       = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    llr_ready = 1'b0;
    en        = 1'b0;
    rd_issue  = 1'b0;
    case (state_q)
      IDLE: begin
        llr_ready = reset;
        if (llr_hs) state_d = LOAD;
      end
      LOAD: begin
        llr_ready = reset;
        if (llr_hs && last_sample) state_d = DECODE;
      end
      DECODE: begin
        // Count 0 is the cycle the final load write is on the bus; en starts after it.
        en = (dec_cnt_q != '0);
        if (dec_done) state_d = READ;
      end
      READ: begin
        rd_issue = credit_ok;
        if (credit_ok && raddr_q == ADDR_WIDTH'(L - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (inflight_q == '0 && fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_q           <= '0;
      int_in        <= '0;
      load_add_in   <= '0;
      pe_select     <= '0;
      column_select <= '0;
      frame_err     <= 1'b0;
    end else begin
      pe_select     <= '0;
      column_select <= '0;
      frame_err     <= 1'b0;
      if (llr_hs) begin
        int_in        <= llr_data;
        load_add_in   <= n_q[ADDR_WIDTH-1:0];
        pe_select     <= pe_onehot(pe_idx);
        column_select <= col_onehot(pe_idx);
        // The frame length is fixed; a misplaced llr_last is only reported.
        frame_err     <= (llr_last != last_sample);
        n_q           <= last_sample ? '0 : n_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_cnt_q <= '0;
    end else if (state_q == DECODE) begin
      dec_cnt_q <= dec_done ? '0 : dec_cnt_q + 1'b1;
    end else begin
      dec_cnt_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raddr_q    <= '0;
      vld_sr     <= '0;
      inflight_q <= '0;
      ocnt_q     <= '0;
      frame_done <= 1'b0;
    end else begin
      if (rd_issue && raddr_q != ADDR_WIDTH'(L - 1)) raddr_q <= raddr_q + 1'b1;
      else if (state_q == DRAIN && state_d == IDLE)  raddr_q <= '0;
      vld_sr[0] <= rd_issue;
      for (int i = 1; i < READ_LATENCY; i++) vld_sr[i] <= vld_sr[i-1];
      case ({rd_issue, push})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
      if (pop) ocnt_q <= (ocnt_q == ADDR_WIDTH'(L - 1)) ? '0 : ocnt_q + 1'b1;
      frame_done <= pop & out_last;
    end
  end

  ldpc_rd_fifo #(
    .WIDTH(KK),
    .DEPTH(FIFO_DEPTH)
  ) u_rd_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (push),
    .push_data(dec_out_fin),
    .pop      (pop),
    .pop_data (out_data),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );
endmodule

// File: tb/tb_ldpc_frame_io_ctrl.sv
// Bench for ldpc_frame_io_ctrl: directed frames, a read-latency decoder model and a per-cycle
// frame-level reference model with an expected-word queue.
module tb_ldpc_frame_io_ctrl;
  import ldpc_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     llr_valid = 1'b0;
  logic                     llr_ready;
  logic [MESSAGE_WIDTH-1:0] llr_data = '0;
  logic                     llr_last = 1'b0;
  logic [MESSAGE_WIDTH-1:0] int_in;
  logic [ADDR_WIDTH-1:0]    load_add_in;
  logic [KK-1:0]            pe_select;
  logic [K-1:0]             column_select;
  logic                     en;
  logic [ADDR_WIDTH-1:0]    read_add_in;
  logic [KK-1:0]            dec_out_fin;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic [KK-1:0]            out_data;
  logic                     out_last;
  logic                     busy;
  logic                     frame_done;
  logic                     frame_err;
  io_state_t                dut_state;

  ldpc_frame_io_ctrl dut (
    .clk(clk), .reset(reset), .llr_valid(llr_valid), .llr_ready(llr_ready),
    .llr_data(llr_data), .llr_last(llr_last), .int_in(int_in), .load_add_in(load_add_in),
    .pe_select(pe_select), .column_select(column_select), .en(en), .read_add_in(read_add_in),
    .dec_out_fin(dec_out_fin), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
    .state(dut_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- decoder model: word for address a appears READ_LATENCY cycles later ----------------
  logic [ADDR_WIDTH-1:0] rd_pipe [READ_LATENCY+1] = '{default: '0};
  always @(negedge clk) begin
    for (int i = READ_LATENCY; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
    rd_pipe[0] = read_add_in;
  end
  assign dec_out_fin = KK'(rd_pipe[READ_LATENCY]);

  // ---------------- reference model + per-cycle compare ----------------
  bit   chk_en = 1'b0;
  int   m_n, pend_n, en_left;
  bit   pend, in_frame, done_pend, prev_stall;
  logic [MESSAGE_WIDTH-1:0] pend_data;
  logic pend_last, prev_last;
  logic [KK-1:0] prev_data;
  logic [KK-1:0] exp_q[$];
  int   pops = 0, dones = 0, errs = 0, en_cnt = 0;

  always @(negedge clk) begin : model
    logic [KK-1:0] w, exp_pe;
    logic [K-1:0]  exp_col;
    bit            exp_ready;
    int            p;
    if (!chk_en) begin
      m_n = 0; pend = 0; en_left = 0; in_frame = 0; done_pend = 0; prev_stall = 0;
      exp_q.delete();
    end else begin
      if (pend && pend_n == 0) in_frame = 1;
      exp_pe = '0; exp_col = '0;
      if (pend) begin
        p = pend_n / L;
        exp_pe[p] = 1'b1;
        exp_col[p / K] = 1'b1;
        check("int_in", int_in, pend_data);
        check("load_add_in", load_add_in, pend_n % L);
      end
      check("pe_select", pe_select, exp_pe);
      check("column_select", column_select, exp_col);
      check("frame_err", frame_err, pend && (pend_last != (pend_n == N_FRAME - 1)));
      if (frame_err) errs++;
      check("en", en, en_left > 0);
      if (en) en_cnt++;
      if (en_left > 0) en_left--;
      if (pend && pend_n == N_FRAME - 1) begin
        en_left = DECODE_CYCLES;
        for (int a = 0; a < L; a++) exp_q.push_back(KK'(a));
      end
      check("busy", busy, in_frame);
      exp_ready = !in_frame || (m_n != 0);
      check("llr_ready", llr_ready, exp_ready);
      if (!in_frame) check("out_valid_idle", out_valid, 1'b0);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, prev_data);
        check("hold_last", out_last, prev_last);
      end
      check("frame_done", frame_done, done_pend);
      if (frame_done) dones++;
      if (done_pend) in_frame = 0;
      done_pend = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL extra_word: got %0h with no word expected at %0t", out_data, $time);
        end else begin
          w = exp_q.pop_front();
          check("out_data", out_data, w);
          check("out_last", out_last, w == KK'(L - 1));
          pops++;
          if (w == KK'(L - 1)) done_pend = 1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      pend      = llr_valid && exp_ready;
      pend_n    = m_n;
      pend_data = llr_data;
      pend_last = llr_last;
      if (pend) m_n = (m_n + 1) % N_FRAME;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int d, input bit last);
    llr_valid = 1'b1;
    llr_data  = MESSAGE_WIDTH'(d);
    llr_last  = last;
    @(posedge clk); #1;
    llr_valid = 1'b0;
    llr_last  = 1'b0;
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input int mult, input int gap, input int early_last);
    for (int n = 0; n < N_FRAME; n++) begin
      bit last;
      last = (early_last >= 0) ? (n == early_last || 0) : (n == N_FRAME - 1);
      send((n * mult) % 32, last);
      if (n == 37 && mult == 1 && gap == 0) begin
        check("s37_int_in", int_in, 5);
        check("s37_load_add_in", load_add_in, 5);
        check("s37_pe_select", pe_select, KK'(1) << 1);
        check("s37_column_select", column_select, 1);
      end
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic wait_en(input logic want, input int limit);
    int c;
    c = 0;
    while (c < limit && en !== want) begin @(negedge clk); c++; end
    check(want ? "en_rise" : "en_fall", en, want);
  endtask

  task automatic wait_frame_done(input int limit);
    int c;
    c = 0;
    while (c < limit && frame_done !== 1'b1) begin @(negedge clk); c++; end
    check("frame_done_seen", frame_done, 1'b1);
    @(negedge clk);
    check("busy_after_done", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic reset_checks();
    check("rst_state", dut_state, IDLE);
    check("rst_llr_ready", llr_ready, 1'b0);
    check("rst_en", en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_pe_select", pe_select, '0);
    check("rst_read_add_in", read_add_in, '0);
    check("rst_frame_done", frame_done, 1'b0);
  endtask

  task automatic apply_reset();
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    reset_checks();
    idle(3);
    reset = 1'b1;
    #1;
    chk_en = 1'b1;
  endtask

  task automatic full_frame(input int mult, input int gap, input int early_last, input int exp_errs);
    int p0, d0, e0, r0;
    p0 = pops; d0 = dones; e0 = en_cnt; r0 = errs;
    load_frame(mult, gap, early_last);
    wait_frame_done(3000);
    check("words_per_frame", pops - p0, L);
    check("done_pulses", dones - d0, 1);
    check("en_cycles", en_cnt - e0, DECODE_CYCLES);
    check("err_pulses", errs - r0, exp_errs);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int p0;
    @(posedge clk); #1;
    apply_reset();
    idle(2);

    full_frame(1, 0, -1, 0);
    full_frame(7, 2, -1, 0);

    // Stall the output stream through READ: the credit rule caps buffered words.
    out_ready = 1'b0;
    p0 = pops;
    load_frame(3, 0, -1);
    wait_en(1'b1, 50);
    wait_en(1'b0, 1000);
    idle(50);
    check("stall_read_add_in", read_add_in, FIFO_DEPTH);
    check("stall_out_valid", out_valid, 1'b1);
    check("stall_no_pops", pops - p0, 0);
    out_ready = 1'b1;
    wait_frame_done(500);
    check("stall_words", pops - p0, L);

    full_frame(5, 0, 100, 2);

    // Abort mid-decode.
    load_frame(9, 0, -1);
    wait_en(1'b1, 50);
    idle(19);
    apply_reset();
    idle(2);
    full_frame(11, 0, -1, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
